// File: rtl/fragment_feeder.sv
// rtl/fragment_feeder.sv - fragment-to-pixel-address feeder with per-frame clear sweep
module fragment_feeder #(
  parameter int unsigned HRES     = 320,
  parameter int unsigned VRES     = 180,
  parameter int unsigned Z_WIDTH  = 15,
  parameter logic [15:0] BG_COLOR = 16'h0,
  localparam int unsigned DEPTH   = HRES * VRES,
  localparam int unsigned XW      = $clog2(HRES),
  localparam int unsigned YW      = $clog2(VRES)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  input  logic               frag_valid_in,
  output logic               frag_ready_out,
  input  logic [XW-1:0]      frag_x_in,
  input  logic [YW-1:0]      frag_y_in,
  input  logic [Z_WIDTH-1:0] frag_z_in,
  input  logic [15:0]        frag_color_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [26:0]        addr_out,
  output logic [Z_WIDTH-1:0] depth_out,
  output logic [15:0]        color_out,
  output logic               frame_out,
  output logic               clear_busy_out,
  output logic               overrun_out,
  output logic [15:0]        drop_count_out
);

  localparam int unsigned CW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_PASS  = 1'b1
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        clr_addr_q;
  logic                 valid_q;
  logic [26:0]          addr_q;
  logic [Z_WIDTH-1:0]   depth_q;
  logic [15:0]          color_q;
  logic                 frame_q;
  logic                 overrun_q;
  logic [15:0]          drop_q;

  logic                 load_en;
  logic                 frag_in_range;
  logic [26:0]          frag_addr;

  // The output register may take a new beat when empty or when its beat leaves this cycle.
  assign load_en       = !valid_q || ready_in;
  assign frag_in_range = (32'(frag_x_in) < HRES) && (32'(frag_y_in) < VRES);
  assign frag_addr     = 27'(frag_y_in) * 27'(HRES) + 27'(frag_x_in);

  // A frame start in PASS takes priority over fragments so none slips in alongside it.
  assign frag_ready_out = (state_q == ST_PASS) && !frame_start_in && load_en;

  assign valid_out      = valid_q;
  assign addr_out       = addr_q;
  assign depth_out      = depth_q;
  assign color_out      = color_q;
  assign frame_out      = frame_q;
  assign clear_busy_out = (state_q == ST_CLEAR);
  assign overrun_out    = overrun_q;
  assign drop_count_out = drop_q;

  // Clear/pass sequencing together with the registered output beat and status counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      depth_q    <= '0;
      color_q    <= '0;
      frame_q    <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (frame_start_in) begin
            overrun_q <= 1'b1;
          end
          // The sweep address only advances on a load, so backpressure never skips or repeats.
          if (load_en) begin
            valid_q <= 1'b1;
            addr_q  <= 27'(clr_addr_q);
            depth_q <= '1;
            color_q <= BG_COLOR;
            if (clr_addr_q == CW'(DEPTH - 1)) begin
              clr_addr_q <= '0;
              state_q    <= ST_PASS;
            end else begin
              clr_addr_q <= clr_addr_q + 1'b1;
            end
          end
        end
        default: begin
          if (frame_start_in) begin
            frame_q <= ~frame_q;
            state_q <= ST_CLEAR;
            // A stalled beat stays put and is delivered before the first clear beat.
            if (load_en) begin
              valid_q <= 1'b0;
            end
          end else if (load_en) begin
            if (frag_valid_in && frag_in_range) begin
              valid_q <= 1'b1;
              addr_q  <= frag_addr;
              depth_q <= frag_z_in;
              color_q <= frag_color_in;
            end else begin
              valid_q <= 1'b0;
            end
            if (frag_valid_in && !frag_in_range && (drop_q != 16'hFFFF)) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
